lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
- Panel-side responder for the 8080-style parallel LCD write bus that our display write path drives (CS, RS, WR, RD, DATA[15:0]).
- Synchronises the bus into the system clock and decodes the command set used by the display path: column set 0x2A, page set 0x2B, memory write 0x2C.
- Tracks the address window and emits one pixel-write strobe per data word, with its x/y coordinate, into a framebuffer.
- Used as an on-chip mirror of the panel and as the checker end of the write path in simulation.

Parameters:
- X_MAX, 239, last valid column; x coordinates are 8 bits.
- Y_MAX, 319, last valid page; y coordinates are 9 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- lcd_cs  in  1  chip select, active low.
- lcd_rs  in  1  0 = command word, 1 = data word.
- lcd_wr  in  1  write strobe; data is captured on its rising edge.
- lcd_rd  in  1  read strobe; reads are not supported and are ignored.
- lcd_data  in  16  bus data.
- pix_we  out  1  one-cycle pixel write strobe.
- pix_x  out  8  column of the pixel being written.
- pix_y  out  9  page of the pixel being written.
- pix_data  out  16  RGB565 pixel value.
- window_done  out  1  one-cycle pulse, coincident with pix_we, when pixel (xe,ye) is written.
- param_err  out  1  sticky flag; cleared only by rst.

Behaviour:
- Reset state:
  - All outputs 0.
  - state = IDLE.
  - Window registers xs=0, xe=X_MAX, ys=0, ye=Y_MAX.
  - Write pointers cx=0, cy=0.
- Input synchronisation:
  - lcd_wr, lcd_rs, lcd_cs and lcd_data pass through 2-flop synchronisers.
  - A WR event is a synchronised 0->1 transition of wr while synchronised cs=0.
  - The rs and data values used are those in the same synchroniser stage as the new wr=1.
  - WR events with cs=1 are ignored.
- Timing:
  - Bus requirement: WR low time and WR high time each >= 2 clk periods.
  - RS, DATA and CS must be stable from WR falling edge until 2 clk after WR rising edge.
  - Latency: pix_we asserts exactly 3 clk after the clk edge that first samples lcd_wr=1 at the pin.
- Command word (rs=0) uses data[7:0] and is accepted in any state:
  - 0x2A -> CASET, param count pc=0.
  - 0x2B -> PASET, pc=0.
  - 0x2C -> RAMWR, and cx<=xs, cy<=ys.
  - Any other value -> IDLE.
  - A new command during CASET or PASET discards any partial parameters; the window is unchanged.
- CASET / PASET data words (rs=1) use data[7:0]. Byte order is SH, SL, EH, EL, with pc counting 0..3.
  - After the 4th byte, start S and end E (16 bit each) are validated:
    - If S > E, or S > limit (X_MAX or Y_MAX), param_err <= 1 and the window is unchanged.
    - Otherwise E is clamped to the limit and the window is written: xs/xe for CASET, ys/ye for PASET.
  - After the 4th byte the state goes to IDLE.
- RAMWR data words (rs=1):
  - pix_we=1 for one cycle; pix_x=cx, pix_y=cy, pix_data=data (all 16 bits).
  - Pointer update:
    - If cx != xe: cx++.
    - Else cx<=xs. Then if cy != ye, cy++; otherwise cy<=ys and window_done=1.
  - The pointer wraps to the window start, so a repeated frame needs no new 0x2C.
  - State remains RAMWR.
- IDLE data words are ignored.
- lcd_rd activity is ignored in all states and does not affect WR decoding.
- Signal hold between events:
  - pix_x, pix_y and pix_data hold their last values between strobes.
  - window_done is 0 except on its strobe cycle.
- CS deassertion mid-transfer does not abort; state, pc and pointers are retained until the next WR event.
- rst mid-operation returns everything to the reset state immediately (asynchronous).

Test Plan:
- Default window: after reset send 0x2C then 3 data words A,B,C -> 3 pix_we at (0,0), (1,0), (2,0), each 3 clk after its WR rise, carrying data A, B, C.
- Window write:
  - Bus sequence: 0x2A + 00,0A,00,0C; then 0x2B + 00,05,00,06; then 0x2C + 6 words.
  - Required coordinates, in order: (10,5) (11,5) (12,5) (10,6) (11,6) (12,6).
  - window_done on the 6th word only.
  - A 7th word writes at (10,5).
- Bad parameters:
  - CASET with S=0x0014, E=0x0010 -> param_err=1; xs/xe unchanged (checked via a subsequent RAMWR at x=0).
  - PASET with E=0x0200 -> window accepted with ye clamped to 319.
- Abort and filtering: CASET with 2 params, then command 0x2C -> the partial CASET is discarded. WR pulses sent with lcd_cs=1 -> no pix_we.
- Reset mid-RAMWR: assert rst after 3 pixels, release it, then send a data word without a new command -> no pix_we (state is IDLE).
- Read activity: lcd_rd toggled continuously during a RAMWR burst -> pixel output is identical to the burst without RD activity.

Source files
------------

// File: rtl/lcd_bus_responder_if.sv
// 8080-style LCD write bus plus the framebuffer pixel port of the responder.
// The master drives the panel bus; the slave is the panel-side responder.
interface lcd_bus_responder_if;
    logic        lcd_cs;
    logic        lcd_rs;
    logic        lcd_wr;
    logic        lcd_rd;
    logic [15:0] lcd_data;
    logic        pix_we;
    logic [7:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] pix_data;
    logic        window_done;
    logic        param_err;

    modport master (
        output lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data,
        input  pix_we, pix_x, pix_y, pix_data, window_done, param_err
    );

    modport slave (
        input  lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_data,
        output pix_we, pix_x, pix_y, pix_data, window_done, param_err
    );
endinterface

// File: rtl/lcd_bus_responder.sv
// Panel-side responder for the 8080 LCD write bus: synchronises the bus, decodes
// CASET/PASET/RAMWR and emits one framebuffer write per RAMWR data word.
module lcd_bus_responder #(
    parameter int X_MAX = 239,
    parameter int Y_MAX = 319
) (
    input logic                clk,
    input logic                rst,
    lcd_bus_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CASET, PASET, RAMWR} state_t;

    localparam logic [15:0] X_LIM = 16'(X_MAX);
    localparam logic [15:0] Y_LIM = 16'(Y_MAX);

    // Synchroniser stages: bit 0 is the first flop, bit 1 the synchronised value,
    // and wr keeps one more stage so its rising edge can be detected.
    logic [2:0]  wr_sync_q, wr_sync_d;
    logic [1:0]  cs_sync_q, cs_sync_d;
    logic [1:0]  rs_sync_q, rs_sync_d;
    logic [15:0] data_s1_q, data_s1_d;
    logic [15:0] data_s2_q, data_s2_d;

    logic        evt_q, evt_d;
    logic        evt_rs_q, evt_rs_d;
    logic [15:0] evt_data_q, evt_data_d;

    state_t      state_q, state_d;
    logic [1:0]  pc_q, pc_d;
    logic [31:0] prm_q, prm_d;
    logic [7:0]  xs_q, xs_d, xe_q, xe_d;
    logic [8:0]  ys_q, ys_d, ye_q, ye_d;
    logic [7:0]  cx_q, cx_d;
    logic [8:0]  cy_q, cy_d;

    logic        pix_we_q, pix_we_d;
    logic [7:0]  pix_x_q, pix_x_d;
    logic [8:0]  pix_y_q, pix_y_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        window_done_q, window_done_d;
    logic        param_err_q, param_err_d;

    logic [15:0] s_w, e_w, lim_w, e_cl_w;
    logic        rd_unused;

    // Reads are not supported; the strobe is deliberately left undecoded.
    assign rd_unused = bus.lcd_rd;

    function automatic logic window_bad(input logic [15:0] s, input logic [15:0] e,
                                        input logic [15:0] lim);
        return (s > e) || (s > lim);
    endfunction

    function automatic logic [15:0] clamp_end(input logic [15:0] e, input logic [15:0] lim);
        return (e > lim) ? lim : e;
    endfunction

    always_comb begin
        wr_sync_d  = {wr_sync_q[1:0], bus.lcd_wr};
        cs_sync_d  = {cs_sync_q[0], bus.lcd_cs};
        rs_sync_d  = {rs_sync_q[0], bus.lcd_rs};
        data_s1_d  = bus.lcd_data;
        data_s2_d  = data_s1_q;
        evt_d      = wr_sync_q[1] & ~wr_sync_q[2] & ~cs_sync_q[1];
        evt_rs_d   = rs_sync_q[1];
        evt_data_d = data_s2_q;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        prm_d         = prm_q;
        xs_d          = xs_q;
        xe_d          = xe_q;
        ys_d          = ys_q;
        ye_d          = ye_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        pix_we_d      = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_data_d    = pix_data_q;
        window_done_d = 1'b0;
        param_err_d   = param_err_q;
        s_w           = '0;
        e_w           = '0;
        lim_w         = '0;
        e_cl_w        = '0;

        if (evt_q) begin
            if (!evt_rs_q) begin
                // Any command restarts parameter collection, discarding partial bytes.
                pc_d = 2'd0;
                case (evt_data_q[7:0])
                    8'h2A: state_d = CASET;
                    8'h2B: state_d = PASET;
                    8'h2C: begin
                        state_d = RAMWR;
                        cx_d    = xs_q;
                        cy_d    = ys_q;
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                case (state_q)
                    CASET, PASET: begin
                        prm_d = {prm_q[23:0], evt_data_q[7:0]};
                        pc_d  = pc_q + 2'd1;
                        if (pc_q == 2'd3) begin
                            state_d = IDLE;
                            s_w     = prm_d[31:16];
                            e_w     = prm_d[15:0];
                            lim_w   = (state_q == CASET) ? X_LIM : Y_LIM;
                            e_cl_w  = clamp_end(e_w, lim_w);
                            if (window_bad(s_w, e_w, lim_w)) begin
                                param_err_d = 1'b1;
                            end else if (state_q == CASET) begin
                                xs_d = s_w[7:0];
                                xe_d = e_cl_w[7:0];
                            end else begin
                                ys_d = s_w[8:0];
                                ye_d = e_cl_w[8:0];
                            end
                        end
                    end
                    RAMWR: begin
                        pix_we_d   = 1'b1;
                        pix_x_d    = cx_q;
                        pix_y_d    = cy_q;
                        pix_data_d = evt_data_q;
                        // Raster order inside the window, wrapping back to its origin.
                        if (cx_q != xe_q) begin
                            cx_d = cx_q + 8'd1;
                        end else begin
                            cx_d = xs_q;
                            if (cy_q != ye_q) begin
                                cy_d = cy_q + 9'd1;
                            end else begin
                                cy_d          = ys_q;
                                window_done_d = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sync_q     <= 3'b111;
            cs_sync_q     <= 2'b11;
            evt_q         <= 1'b0;
            state_q       <= IDLE;
            pc_q          <= 2'd0;
            xs_q          <= 8'd0;
            xe_q          <= X_LIM[7:0];
            ys_q          <= 9'd0;
            ye_q          <= Y_LIM[8:0];
            cx_q          <= 8'd0;
            cy_q          <= 9'd0;
            pix_we_q      <= 1'b0;
            pix_x_q       <= 8'd0;
            pix_y_q       <= 9'd0;
            pix_data_q    <= 16'd0;
            window_done_q <= 1'b0;
            param_err_q   <= 1'b0;
        end else begin
            wr_sync_q     <= wr_sync_d;
            cs_sync_q     <= cs_sync_d;
            evt_q         <= evt_d;
            state_q       <= state_d;
            pc_q          <= pc_d;
            xs_q          <= xs_d;
            xe_q          <= xe_d;
            ys_q          <= ys_d;
            ye_q          <= ye_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            pix_we_q      <= pix_we_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            window_done_q <= window_done_d;
            param_err_q   <= param_err_d;
        end
    end

    // Data-only stages: their contents are qualified by evt_q / pc_q.
    always_ff @(posedge clk) begin
        rs_sync_q  <= rs_sync_d;
        data_s1_q  <= data_s1_d;
        data_s2_q  <= data_s2_d;
        evt_rs_q   <= evt_rs_d;
        evt_data_q <= evt_data_d;
        prm_q      <= prm_d;
    end

    assign bus.pix_we      = pix_we_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_data    = pix_data_q;
    assign bus.window_done = window_done_q;
    assign bus.param_err   = param_err_q;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: drives 8080 bus words and scoreboards every
// pixel strobe (coordinate, data, window_done and latency).
module tb_lcd_bus_responder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nc = 0;
    int   nf = 0;
    logic rd_en = 1'b0;

    typedef struct {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
        logic        done;
        int          at;
    } exp_t;

    typedef struct {
        logic        rs;
        logic [15:0] d;
        logic        exp;
        logic [7:0]  x;
        logic [8:0]  y;
        logic        done;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[18];

    lcd_bus_responder_if bus();

    lcd_bus_responder #(.X_MAX(239), .Y_MAX(319)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nc++;
        if (act !== req) begin
            nf++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Pixel monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.pix_we) begin
                if (sb.size() == 0) begin
                    nc++;
                    nf++;
                    $display("FAIL unexpected_pix_we: got strobe at (%0d,%0d) data 0x%0h, required none",
                             bus.pix_x, bus.pix_y, bus.pix_data);
                end else begin
                    e = sb.pop_front();
                    check("pix_x", 32'(bus.pix_x), 32'(e.x));
                    check("pix_y", 32'(bus.pix_y), 32'(e.y));
                    check("pix_data", 32'(bus.pix_data), 32'(e.d));
                    check("window_done", 32'(bus.window_done), 32'(e.done));
                    check("latency_cycle", 32'(cyc), 32'(e.at));
                end
            end else if (bus.window_done) begin
                nc++;
                nf++;
                $display("FAIL done_without_we: got window_done=1 with pix_we=0, required 0");
            end
        end
    end

    task automatic bus_write(input logic rs, input logic [15:0] d, input logic cs,
                             input logic exp, input logic [7:0] x, input logic [8:0] y,
                             input logic done);
        @(negedge clk);
        bus.lcd_cs   = cs;
        bus.lcd_rs   = rs;
        bus.lcd_data = d;
        bus.lcd_wr   = 1'b0;
        repeat (3) @(negedge clk);
        bus.lcd_wr = 1'b1;
        if (exp) sb.push_back('{x, y, d, done, cyc + 4});
        repeat (3) @(negedge clk);
    endtask

    task automatic cmd(input logic [15:0] c);
        bus_write(1'b0, c, 1'b0, 1'b0, 8'd0, 9'd0, 1'b0);
    endtask

    task automatic dat(input logic [15:0] d);
        bus_write(1'b1, d, 1'b0, 1'b0, 8'd0, 9'd0, 1'b0);
    endtask

    task automatic pix(input logic [15:0] d, input logic [7:0] x, input logic [8:0] y,
                       input logic done);
        bus_write(1'b1, d, 1'b0, 1'b1, x, y, done);
    endtask

    task automatic drain();
        int   n = 0;
        exp_t e;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            nc++;
            nf++;
            $display("FAIL missing_pix_we: got no strobe, required (%0d,%0d) data 0x%0h", e.x, e.y, e.d);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pix_we"}, 32'(bus.pix_we), 32'd0);
        check({tag, "_pix_x"}, 32'(bus.pix_x), 32'd0);
        check({tag, "_pix_y"}, 32'(bus.pix_y), 32'd0);
        check({tag, "_pix_data"}, 32'(bus.pix_data), 32'd0);
        check({tag, "_window_done"}, 32'(bus.window_done), 32'd0);
        check({tag, "_param_err"}, 32'(bus.param_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.lcd_cs = 1'b1;
        bus.lcd_wr = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.lcd_cs   = 1'b1;
        bus.lcd_rs   = 1'b0;
        bus.lcd_wr   = 1'b1;
        bus.lcd_rd   = 1'b1;
        bus.lcd_data = 16'd0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Default full-screen window
        cmd(16'h002C);
        pix(16'hA5A5, 8'd0, 9'd0, 1'b0);
        pix(16'h5A5A, 8'd1, 9'd0, 1'b0);
        pix(16'h1234, 8'd2, 9'd0, 1'b0);
        drain();

        // Window 10..12 x 5..6, then a wrapping 7th word
        tbl[0]  = '{1'b0, 16'h002A, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[1]  = '{1'b1, 16'h0000, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[2]  = '{1'b1, 16'h000A, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[3]  = '{1'b1, 16'h0000, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[4]  = '{1'b1, 16'h000C, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[5]  = '{1'b0, 16'h002B, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[6]  = '{1'b1, 16'h0000, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[7]  = '{1'b1, 16'h0005, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[8]  = '{1'b1, 16'h0000, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[9]  = '{1'b1, 16'h0006, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[10] = '{1'b0, 16'h002C, 1'b0, 8'd0,  9'd0, 1'b0};
        tbl[11] = '{1'b1, 16'hF800, 1'b1, 8'd10, 9'd5, 1'b0};
        tbl[12] = '{1'b1, 16'h07E0, 1'b1, 8'd11, 9'd5, 1'b0};
        tbl[13] = '{1'b1, 16'h001F, 1'b1, 8'd12, 9'd5, 1'b0};
        tbl[14] = '{1'b1, 16'hFFFF, 1'b1, 8'd10, 9'd6, 1'b0};
        tbl[15] = '{1'b1, 16'h8410, 1'b1, 8'd11, 9'd6, 1'b0};
        tbl[16] = '{1'b1, 16'h0841, 1'b1, 8'd12, 9'd6, 1'b1};
        tbl[17] = '{1'b1, 16'hC618, 1'b1, 8'd10, 9'd5, 1'b0};
        for (int i = 0; i < 18; i++)
            bus_write(tbl[i].rs, tbl[i].d, 1'b0, tbl[i].exp, tbl[i].x, tbl[i].y, tbl[i].done);
        drain();
        check("param_err_clean", 32'(bus.param_err), 32'd0);

        // Bad CASET (S > E) leaves the default window in place
        do_reset();
        cmd(16'h002A); dat(16'h0000); dat(16'h0014); dat(16'h0000); dat(16'h0010);
        repeat (2) @(negedge clk);
        check("param_err_set", 32'(bus.param_err), 32'd1);
        cmd(16'h002C);
        pix(16'hBEEF, 8'd0, 9'd0, 1'b0);
        pix(16'hCAFE, 8'd1, 9'd0, 1'b0);
        drain();

        // PASET end 0x200 clamps to 319: rows 318,319 then wrap
        cmd(16'h002A); dat(16'h0000); dat(16'h0000); dat(16'h0000); dat(16'h0000);
        cmd(16'h002B); dat(16'h0001); dat(16'h003E); dat(16'h0002); dat(16'h0000);
        cmd(16'h002C);
        pix(16'h0101, 8'd0, 9'd318, 1'b0);
        pix(16'h0202, 8'd0, 9'd319, 1'b1);
        pix(16'h0303, 8'd0, 9'd318, 1'b0);
        drain();

        // Partial CASET aborted by RAMWR, then a clean CASET 3..4
        cmd(16'h002A); dat(16'h0000); dat(16'h0005);
        cmd(16'h002C);
        pix(16'h0404, 8'd0, 9'd318, 1'b0);
        cmd(16'h002A); dat(16'h0000); dat(16'h0003); dat(16'h0000); dat(16'h0004);
        cmd(16'h002C);
        pix(16'h0505, 8'd3, 9'd318, 1'b0);
        pix(16'h0606, 8'd4, 9'd318, 1'b0);

        // WR pulses with CS high must not strobe or advance the pointer
        for (int i = 0; i < 3; i++)
            bus_write(1'b1, 16'hDEAD, 1'b1, 1'b0, 8'd0, 9'd0, 1'b0);
        pix(16'h0707, 8'd3, 9'd319, 1'b0);
        drain();

        // Asynchronous reset mid-RAMWR
        do_reset();
        check("param_err_cleared", 32'(bus.param_err), 32'd0);
        cmd(16'h002C);
        pix(16'h1111, 8'd0, 9'd0, 1'b0);
        pix(16'h2222, 8'd1, 9'd0, 1'b0);
        pix(16'h3333, 8'd2, 9'd0, 1'b0);
        drain();
        #3 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        dat(16'h4444);
        repeat (6) @(negedge clk);

        // RD toggling during a burst must not change the pixel stream
        cmd(16'h002C);
        rd_en = 1'b1;
        fork
            begin
                while (rd_en) begin
                    #3 bus.lcd_rd = ~bus.lcd_rd;
                end
                bus.lcd_rd = 1'b1;
            end
        join_none
        pix(16'hAAAA, 8'd0, 9'd0, 1'b0);
        pix(16'h5555, 8'd1, 9'd0, 1'b0);
        pix(16'h0F0F, 8'd2, 9'd0, 1'b0);
        pix(16'hF0F0, 8'd3, 9'd0, 1'b0);
        rd_en = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
